// File: rtl/rx_window_ctrl.sv
// Receive-window controller: blanks the sample stream after a reader command,
// listens for a tag reply edge, then forwards samples until stop/timeout/overrun.
module rx_window_ctrl #(
  parameter int unsigned BLANK_CNT  = 40,
  parameter int unsigned LISTEN_CNT = 400,
  parameter int unsigned MAX_CNT    = 4096,
  parameter int unsigned CW         = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic smp_dat,
  input  logic smp_vld,
  input  logic stop,
  output logic win_dat,
  output logic win_vld,
  output logic busy,
  output logic rx_active,
  output logic done,
  output logic timeout,
  output logic overrun
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BLANK  = 2'd1;
  localparam logic [1:0] S_LISTEN = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CNT - 1);
  localparam logic [CW-1:0] LISTEN_LAST = CW'(LISTEN_CNT - 1);
  localparam logic [CW-1:0] MAX_LAST    = CW'(MAX_CNT - 1);

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          prev, prev_nx;
  logic          fwd, done_nx, timeout_nx, overrun_nx;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    prev_nx    = prev;
    fwd        = 1'b0;
    done_nx    = 1'b0;
    timeout_nx = 1'b0;
    overrun_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_BLANK;
          cnt_nx   = '0;
        end
      end
      S_BLANK: begin
        if (smp_vld) begin
          prev_nx = smp_dat;
          if (cnt == BLANK_LAST) begin
            state_nx = S_LISTEN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      S_LISTEN: begin
        if (smp_vld) begin
          fwd     = 1'b1;
          prev_nx = smp_dat;
          // A reply edge on the final listen strobe still opens the window.
          if (smp_dat != prev) begin
            state_nx = S_ACTIVE;
            cnt_nx   = '0;
          end else if (cnt == LISTEN_LAST) begin
            state_nx   = S_IDLE;
            cnt_nx     = '0;
            timeout_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      S_ACTIVE: begin
        fwd = smp_vld;
        if (stop) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          done_nx  = 1'b1;
        end else if (smp_vld) begin
          if (cnt == MAX_LAST) begin
            state_nx   = S_IDLE;
            cnt_nx     = '0;
            overrun_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Abort overrides everything below reset and suppresses forwarding and status.
    if (abort && (state != S_IDLE)) begin
      state_nx   = S_IDLE;
      cnt_nx     = '0;
      fwd        = 1'b0;
      done_nx    = 1'b0;
      timeout_nx = 1'b0;
      overrun_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      prev      <= 1'b0;
      win_dat   <= 1'b0;
      win_vld   <= 1'b0;
      busy      <= 1'b0;
      rx_active <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      prev      <= prev_nx;
      win_vld   <= fwd;
      if (fwd) win_dat <= smp_dat;
      busy      <= (state_nx != S_IDLE);
      rx_active <= (state_nx == S_ACTIVE);
      done      <= done_nx;
      timeout   <= timeout_nx;
      overrun   <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_rx_window_ctrl.sv
// Scoreboard bench for rx_window_ctrl: a frame-level model predicts forwarded
// samples and status pulses; a monitor pops and compares them as they appear.
module tb_rx_window_ctrl;
  localparam int B = 4, L = 8, M = 16, W = 5;
  localparam int SEQ_LEN = B + L + M + 2;

  logic clk = 1'b0;
  logic rst, start, abort, smp_dat, smp_vld, stop;
  logic win_dat, win_vld, busy, rx_active, done, timeout, overrun;

  always #5 clk = ~clk;

  rx_window_ctrl #(.BLANK_CNT(B), .LISTEN_CNT(L), .MAX_CNT(M), .CW(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .smp_dat(smp_dat),
    .smp_vld(smp_vld), .stop(stop), .win_dat(win_dat), .win_vld(win_vld),
    .busy(busy), .rx_active(rx_active), .done(done), .timeout(timeout),
    .overrun(overrun)
  );

  // kind: 0 forwarded sample, 1 done, 2 timeout, 3 overrun (4 = abort, never queued)
  typedef struct {
    int kind;
    bit dat;
    int cyc;
    bit bsy;
    bit act;
  } ev_t;

  ev_t exq[$];
  bit  sdat[$];
  int  checks = 0, errors = 0;
  int  cyc = 0;
  int  vld_seen = 0, act_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic pop(input int kind);
    ev_t e;
    if (exq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
      return;
    end
    e = exq.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
    if (kind == 0) chk("win_dat", win_dat, e.dat);
    chk("busy_at_event", busy, e.bsy);
    chk("rx_active_at_event", rx_active, e.act);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rx_active === 1'b1) act_seen++;
    if (win_vld === 1'b1) begin
      vld_seen++;
      pop(0);
    end
    if (done === 1'b1) pop(1);
    if (timeout === 1'b1) pop(2);
    if (overrun === 1'b1) pop(3);
  end

  task automatic drv(input bit st, input bit ab, input bit vl, input bit dt, input bit sp);
    @(negedge clk);
    start = st; abort = ab; smp_vld = vl; smp_dat = dt; stop = sp;
  endtask

  task automatic set_step(input int k);
    sdat.delete();
    for (int j = 0; j < SEQ_LEN; j++) sdat.push_back(j >= k);
  endtask

  // stop_k / abort_k: ACTIVE strobe count after which the event occurs (0 = never).
  task automatic run_frame(input int stop_k, input bit stop_coinc, input int abort_k,
                           input int exp_vld, input int exp_act);
    int edge_i, n_last, term_kind, term_delay, rank, r, vld0, act0;
    bit act_f, bsy_f, stray_stop;
    edge_i = -1;
    for (int j = B; j < B + L; j++)
      if (sdat[j] != sdat[j-1]) begin edge_i = j; break; end
    if (edge_i < 0) begin
      n_last = B + L - 1; term_kind = 2; term_delay = 0;
    end else begin
      rank = 2 * M; term_kind = 3;
      if (stop_k > 0) begin
        r = stop_coinc ? 2 * stop_k : 2 * stop_k + 1;
        if (r <= rank) begin rank = r; term_kind = 1; end
      end
      if (abort_k > 0) begin
        r = 2 * abort_k + 1;
        if (r < rank) begin rank = r; term_kind = 4; end
      end
      n_last = edge_i + rank / 2;
      term_delay = (rank % 2 == 1) ? 3 : 0;
    end
    vld0 = vld_seen; act0 = act_seen;
    drv(0, 1, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("busy_after_start", busy, 1);
    for (int s = 0; s <= n_last; s++) begin
      stray_stop = (s == 2) || (s == B + 1 && (edge_i < 0 || edge_i > B));
      for (int g = 0; g < 9; g++) drv(g == 4 && s == 1, 0, 0, 0, g == 4 && stray_stop);
      drv(0, 0, 1, sdat[s], term_kind == 1 && term_delay == 0 && s == n_last);
      bsy_f = !(s == n_last && term_delay == 0);
      act_f = bsy_f && edge_i >= 0 && s >= edge_i;
      if (s >= B) exq.push_back(ev_t'{0, sdat[s], cyc + 1, bsy_f, act_f});
      if (s == n_last && term_delay == 0) exq.push_back(ev_t'{term_kind, 1'b0, cyc + 1, 1'b0, 1'b0});
    end
    if (term_delay != 0) begin
      drv(0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0);
      drv(0, term_kind == 4, 0, 0, term_kind == 1);
      if (term_kind == 1) exq.push_back(ev_t'{1, 1'b0, cyc + 1, 1'b0, 1'b0});
    end
    drv(0, 0, 0, 0, 0);
    chk("busy_after_end", busy, 0);
    chk("rx_active_after_end", rx_active, 0);
    if (term_kind == 4) chk("win_vld_after_abort", win_vld, 0);
    repeat (3) drv(0, 0, 0, 0, 0);
    chk("queue_drained", exq.size(), 0);
    if (exp_vld >= 0) chk("frame_win_vld_count", vld_seen - vld0, exp_vld);
    if (exp_act >= 0) chk("frame_rx_active_cycles", act_seen - act0, exp_act);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int base, e;
    rst = 1'b1; start = 0; abort = 0; smp_dat = 0; smp_vld = 0; stop = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {win_dat, win_vld, busy, rx_active, done, timeout, overrun}, 0);
    rst = 1'b0;

    set_step(6);  run_frame(4, 0, 0, 7, -1);   // normal frame, edge on 3rd listen strobe
    set_step(0);  run_frame(0, 0, 0, 8, 0);    // constant data -> timeout
    set_step(4);  run_frame(0, 0, 0, 17, -1);  // no stop -> overrun
    set_step(11); run_frame(16, 1, 0, 24, -1); // edge on last listen strobe, stop with 16th
    set_step(4);  run_frame(0, 0, 3, 4, -1);   // abort in ACTIVE

    // rst in LISTEN after two forwarded strobes
    drv(1, 0, 0, 0, 0);
    for (int s = 0; s < B + 2; s++) begin
      repeat (9) drv(0, 0, 0, 0, 0);
      drv(0, 0, 1, 1'b0, 0);
      if (s >= B) exq.push_back(ev_t'{0, 1'b0, cyc + 1, 1'b1, 1'b0});
    end
    drv(0, 0, 0, 0, 0);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("outputs_after_rst", {win_vld, busy, rx_active, done, timeout, overrun}, 0);
    set_step(6);  run_frame(4, 0, 0, 7, -1);

    for (int f = 0; f < 20; f++) begin
      base = $urandom_range(0, 1);
      e = $urandom_range(0, L);
      sdat.delete();
      for (int j = 0; j < SEQ_LEN; j++) begin
        if (j < B - 1 || j > B + e) sdat.push_back(bit'($urandom_range(0, 1)));
        else if (j == B + e && e < L) sdat.push_back(!base);
        else sdat.push_back(bit'(base));
      end
      run_frame($urandom_range(0, M + 2), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, M) : 0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
